// File: rtl/ifu_prefetch_if.sv
// Fetch front-end bundle: instruction memory request/response,
// decode-side instruction handshake and next-PC redirect.
interface ifu_prefetch_if;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output im_req_valid, im_req_addr,
    output instr_valid, instr, instr_pc,
    input  im_req_ready, im_rsp_valid, im_rsp_data,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  im_req_valid, im_req_addr,
    input  instr_valid, instr, instr_pc,
    output im_req_ready, im_rsp_valid, im_rsp_data,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: credit-based word fetch into a small
// {word, pc} queue, with redirect flush and stale-response discard.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  ifu_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  logic [31:0]   fpc;
  logic [31:0]   q_word [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   tag    [DEPTH];
  logic [AW-1:0] q_rd, q_wr, t_rd, t_wr;
  logic [CW-1:0] count, inflight, discard;
  logic [CW:0]   used;
  logic          issue, acc, rsp, push, pop, redir, head;

  assign redir = bus.redirect_valid;
  assign used  = {1'b0, count} + {1'b0, inflight};
  // credits cover both queued and in-flight words
  assign issue = reset && !redir && (used < LIMIT);
  assign acc   = issue && bus.im_req_ready;
  assign rsp   = bus.im_rsp_valid;
  assign push  = rsp && !redir && (discard == '0);
  assign head  = count != '0;
  assign pop   = head && bus.instr_ready;

  assign bus.im_req_valid = issue;
  assign bus.im_req_addr  = issue ? fpc : '0;
  assign bus.instr_valid  = head;
  assign bus.instr        = head ? q_word[q_rd] : '0;
  assign bus.instr_pc     = head ? q_pc[q_rd] : '0;

  always_ff @(posedge clk) begin
    if (acc) tag[t_wr] <= fpc;
    if (push) begin
      q_word[q_wr] <= bus.im_rsp_data;
      q_pc[q_wr]   <= tag[t_rd];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc      <= RESET_PC;
      q_rd     <= '0;
      q_wr     <= '0;
      t_rd     <= '0;
      t_wr     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(acc) - CW'(rsp);
      if (redir) begin
        fpc     <= bus.redirect_pc & ~32'h3;
        q_rd    <= '0;
        q_wr    <= '0;
        t_rd    <= '0;
        t_wr    <= '0;
        count   <= '0;
        // everything still outstanding is now stale
        discard <= inflight - CW'(rsp);
      end else begin
        if (acc) begin
          fpc  <= fpc + 32'd4;
          t_wr <= t_wr + AW'(1);
        end
        if (rsp && discard != '0) discard <= discard - CW'(1);
        if (push) begin
          q_wr <= q_wr + AW'(1);
          t_rd <= t_rd + AW'(1);
        end
        if (pop) q_rd <= q_rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: in-order memory model with
// configurable latency, expected PC stream rebuilt from each redirect.
module tb_ifu_prefetch;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifu_prefetch_if intf ();

  ifu_prefetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(intf)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;
  exp_t  exp_q [$];
  mreq_t mq [$];
  logic [31:0] acc_log [$];
  logic [31:0] mfpc;
  exp_t mon_e;

  logic        s_ivalid, s_rvalid, s_rsp;
  logic [31:0] s_ipc, s_raddr;
  int          s_inflight;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // one clock cycle: drive at negedge, sample at +1, book-keep at +3
  task automatic step(input bit rq_rdy, input bit in_rdy,
                      input bit redir, input logic [31:0] rpc);
    int d;
    @(negedge clk);
    intf.im_req_ready   = rq_rdy;
    intf.instr_ready    = in_rdy;
    intf.redirect_valid = redir;
    intf.redirect_pc    = redir ? rpc : 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      intf.im_rsp_valid = 1'b1;
      intf.im_rsp_data  = mem(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      intf.im_rsp_valid = 1'b0;
      intf.im_rsp_data  = 32'h0;
    end
    #1;
    s_ivalid   = intf.instr_valid;
    s_ipc      = intf.instr_pc;
    s_rvalid   = intf.im_req_valid;
    s_raddr    = intf.im_req_addr;
    s_rsp      = intf.im_rsp_valid;
    s_inflight = int'(dut.inflight);
    #2;
    if (redir) begin
      chk("req_blocked_on_redirect", {31'b0, s_rvalid}, 32'h0);
      exp_q.delete();
      mfpc = rpc & ~32'h3;
    end else if (s_rvalid && rq_rdy) begin
      chk("req_addr", s_raddr, mfpc);
      exp_q.push_back('{pc: mfpc, word: mem(mfpc)});
      acc_log.push_back(s_raddr);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{addr: s_raddr, due: d});
      last_due = d;
      mfpc = mfpc + 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    intf.im_req_ready   = 1'b0;
    intf.instr_ready    = 1'b0;
    intf.redirect_valid = 1'b0;
    intf.redirect_pc    = 32'h0;
    intf.im_rsp_valid   = 1'b0;
    intf.im_rsp_data    = 32'h0;
    mq.delete();
    exp_q.delete();
    acc_log.delete();
    @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, intf.im_req_valid}, 32'h0);
    chk("rst_req_addr", intf.im_req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, intf.instr_valid}, 32'h0);
    chk("rst_instr", intf.instr, 32'h0);
    chk("rst_instr_pc", intf.instr_pc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mfpc = RPC;
    last_due = cyc;
  endtask

  // monitor: pops the scoreboard on every head handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (intf.instr_valid && intf.instr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h want none",
                     intf.instr_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("instr_pc", intf.instr_pc, mon_e.pc);
            chk("instr_word", intf.instr, mon_e.word);
          end
        end
        if (!intf.instr_valid) begin
          chk("idle_instr", intf.instr, 32'h0);
          chk("idle_pc", intf.instr_pc, 32'h0);
        end
        chk("credit_bound",
            {31'b0, (int'(dut.count) + int'(dut.inflight)) <= DEPTH},
            32'h1);
        if (intf.im_rsp_valid)
          chk("rsp_with_inflight", {31'b0, dut.inflight != '0}, 32'h1);
        if (intf.im_rsp_valid && dut.discard == '0 && !intf.redirect_valid)
          chk("push_not_full", {31'b0, int'(dut.count) < DEPTH}, 32'h1);
      end
    end
  end

  initial begin
    logic [31:0] first_pc;
    bit          seen;

    // reset then streaming with 1-cycle memory
    do_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        chk("first_req_valid", {31'b0, s_rvalid}, 32'h1);
        chk("first_req_addr", s_raddr, RPC);
      end
      chk("stream_valid", {31'b0, s_ivalid}, {31'b0, i >= 2});
      if (i == 2) chk("first_instr_pc", s_ipc, RPC);
    end

    // back-pressure: queue fills, credits run out
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("bp_count", {29'b0, dut.count}, 32'd4);
    chk("bp_inflight", {29'b0, dut.inflight}, 32'd0);
    chk("bp_req_valid", {31'b0, intf.im_req_valid}, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // redirect with three stale requests, coincident rsp and pop
    do_reset();
    lat = 3;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3100);
    chk("stale_inflight", s_inflight, 32'd3);
    chk("stale_rsp", {31'b0, s_rsp}, 32'h1);
    chk("stale_head_pop", {31'b0, s_ivalid}, 32'h1);
    #1;
    chk("redir_discard", {29'b0, dut.discard}, 32'd2);
    chk("redir_flushed", {31'b0, intf.instr_valid}, 32'h0);
    seen = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_ivalid && !seen) begin
        seen = 1'b1;
        first_pc = s_ipc;
      end
    end
    chk("redir_first_pc", first_pc, 32'h0000_3100);

    // redirect latency with 1-cycle memory
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_4000);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("redir_lat_valid", {31'b0, s_ivalid}, {31'b0, i == 3});
      if (i == 3) chk("redir_lat_pc", s_ipc, 32'h0000_4000);
    end

    // misaligned redirect and address wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    acc_log.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    if (acc_log.size() < 2) begin
      checks++;
      errors++;
      $display("FAIL wrap_reqs: got %0d requests want 2", acc_log.size());
    end else begin
      chk("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", acc_log[1], 32'h0000_0000);
    end

    // random stalls and redirects
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom);
    end

    // drain: stop fetching, everything expected must come out
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_valid", {31'b0, s_ivalid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
